// File: rtl/term_loopback_checker_if.sv
// Bus between the loopback checker and the termination tile it exercises.
// master = checker side; slave = terminal/wrapper side.
interface term_loopback_checker_if #(
    parameter int ERR_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [3:0]        N1BEG;
    logic [7:0]        N2BEG;
    logic [7:0]        N2BEGb;
    logic [15:0]       N4BEG;
    logic [3:0]        S1END;
    logic [7:0]        S2MID;
    logic [7:0]        S2END;
    logic [15:0]       S4END;
    logic [35:0]       first_err_vec;
    logic [15:0]       first_err_idx;

    modport master (
        input  start, S1END, S2MID, S2END, S4END,
        output busy, done, pass, err_count, N1BEG, N2BEG, N2BEGb, N4BEG,
               first_err_vec, first_err_idx
    );
    modport slave (
        output start, S1END, S2MID, S2END, S4END,
        input  busy, done, pass, err_count, N1BEG, N2BEG, N2BEGb, N4BEG,
               first_err_vec, first_err_idx
    );
endinterface

// File: rtl/term_loopback_checker.sv
// BIST initiator for a north-edge termination tile: drives LFSR vectors north, checks the reversed echo.
// Optional first-error log built only when TERM_LOOP_ERRLOG_EN is defined.
module term_loopback_checker #(
    parameter int          LOOP_LAT  = 0,
    parameter int          RUN_LEN   = 1024,
    parameter logic [35:0] LFSR_SEED = 36'h0_A5A5_1234,
    parameter int          ERR_W     = 16
) (
    input  logic CLK,
    input  logic resetn,
    term_loopback_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int CW = $clog2(RUN_LEN + LOOP_LAT + 2);
    localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((LOOP_LAT > 0) ? LOOP_LAT - 1 : 0);
`ifdef TERM_LOOP_ERRLOG_EN
    localparam int PW = 52;
`else
    localparam int PW = 36;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [35:0]       vec_q, vec_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              start_run;
    logic              cur_vld, chk_vld, mismatch;
    logic [PW-1:0]     cur_pay, chk_pay;
    logic [35:0]       ret, diff;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_run = 1'b0;
        vec_d     = '0;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d   = RUN;
                cnt_d     = '0;
                start_run = 1'b1;
            end
            RUN: if (cnt_q == RUN_LAST) begin
                cnt_d   = '0;
                state_d = (LOOP_LAT == 0) ? DONE : DRAIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DRAIN: if (cnt_q == DRAIN_LAST) state_d = DONE;
                   else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // x^36 + x^25 + 1 Fibonacci step; seed is loaded on the edge entering RUN
        if (state_d == RUN)
            vec_d = (state_q == RUN) ? {vec_q[34:0], vec_q[35] ^ vec_q[24]} : LFSR_SEED;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    assign cur_vld = (state_q == RUN);
`ifdef TERM_LOOP_ERRLOG_EN
    assign cur_pay = {16'(cnt_q), vec_q};
`else
    assign cur_pay = vec_q;
`endif

    generate
        if (LOOP_LAT == 0) begin : g_comb
            assign chk_vld = cur_vld;
            assign chk_pay = cur_pay;
        end else begin : g_pipe
            logic [LOOP_LAT-1:0]         vld_pipe;
            logic [LOOP_LAT-1:0][PW-1:0] pay_pipe;
            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn) begin
                    vld_pipe <= '0;
                    pay_pipe <= '0;
                end else begin
                    vld_pipe[0] <= cur_vld;
                    pay_pipe[0] <= cur_pay;
                    for (int k = 1; k < LOOP_LAT; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        pay_pipe[k] <= pay_pipe[k-1];
                    end
                end
            end
            assign chk_vld = vld_pipe[LOOP_LAT-1];
            assign chk_pay = pay_pipe[LOOP_LAT-1];
        end
    endgenerate

    // Undo the terminal's index reversal so diff lines up with the N* bit order
    always_comb begin
        ret = '0;
        for (int i = 0; i < 4; i++)  ret[i]      = bus.S1END[3-i];
        for (int i = 0; i < 8; i++)  ret[4+i]    = bus.S2MID[7-i];
        for (int i = 0; i < 8; i++)  ret[12+i]   = bus.S2END[7-i];
        for (int i = 0; i < 16; i++) ret[20+i]   = bus.S4END[15-i];
    end

    assign diff     = chk_pay[35:0] ^ ret;
    assign mismatch = chk_vld && (diff != '0);

    always_comb begin
        err_d = err_q;
        if (start_run)
            err_d = '0;
        else if (mismatch && (err_q != {ERR_W{1'b1}}))
            err_d = err_q + 1'b1;
    end

`ifdef TERM_LOOP_ERRLOG_EN
    logic [35:0] fev_q;
    logic [15:0] fei_q;
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            fev_q <= '0;
            fei_q <= '0;
        end else if (start_run) begin
            fev_q <= '0;
            fei_q <= '0;
        end else if (mismatch && (err_q == '0)) begin
            fev_q <= diff;
            fei_q <= chk_pay[51:36];
        end
    end
    assign bus.first_err_vec = fev_q;
    assign bus.first_err_idx = fei_q;
`else
    assign bus.first_err_vec = '0;
    assign bus.first_err_idx = '0;
`endif

    assign bus.N1BEG     = vec_q[3:0];
    assign bus.N2BEG     = vec_q[11:4];
    assign bus.N2BEGb    = vec_q[19:12];
    assign bus.N4BEG     = vec_q[35:20];
    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = (state_q == DONE) && (err_q == '0);
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_term_loopback_checker.sv
// Bench for term_loopback_checker: two instances (combinational loop and 3-cycle loop),
// a table of runs with fault injection on the return path, and a mid-run reset sequence.
module tb_term_loopback_checker;
  localparam logic [35:0] SEED = 36'h0_A5A5_1234;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  term_loopback_checker_if #(.ERR_W(16)) b0();
  term_loopback_checker_if #(.ERR_W(4))  b3();

  term_loopback_checker #(.LOOP_LAT(0), .RUN_LEN(16), .LFSR_SEED(SEED), .ERR_W(16))
    dut0 (.CLK(clk), .resetn(resetn), .bus(b0));
  term_loopback_checker #(.LOOP_LAT(3), .RUN_LEN(32), .LFSR_SEED(SEED), .ERR_W(4))
    dut3 (.CLK(clk), .resetn(resetn), .bus(b3));

  int          mode = 0;
  logic [35:0] flipvec = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] exp_q[$];

  function automatic logic [35:0] step(input logic [35:0] v);
    return {v[34:0], v[35] ^ v[24]};
  endfunction

  // Terminal model: reversed groups packed {S4END,S2END,S2MID,S1END}, then fault injection
  function automatic logic [35:0] term(input logic [35:0] v, input int m, input logic [35:0] fv);
    logic [35:0] s;
    for (int i = 0; i < 4; i++)  s[i]    = v[3-i];
    for (int i = 0; i < 8; i++)  s[4+i]  = v[11-i];
    for (int i = 0; i < 8; i++)  s[12+i] = v[19-i];
    for (int i = 0; i < 16; i++) s[20+i] = v[35-i];
    case (m)
      1: s[20] = 1'b1;
      2: if (v == fv) s[2] = ~s[2];
      3: s[0] = ~s[0];
      default: ;
    endcase
    return s;
  endfunction

  logic [35:0] n0, n3, p1 = '0, p2 = '0, p3 = '0;
  assign n0 = {b0.N4BEG, b0.N2BEGb, b0.N2BEG, b0.N1BEG};
  assign n3 = {b3.N4BEG, b3.N2BEGb, b3.N2BEG, b3.N1BEG};
  always @(posedge clk) begin
    p1 <= n3;
    p2 <= p1;
    p3 <= p2;
  end
  always_comb {b0.S4END, b0.S2END, b0.S2MID, b0.S1END} = term(n0, mode, flipvec);
  always_comb {b3.S4END, b3.S2END, b3.S2MID, b3.S1END} = term(p3, mode, flipvec);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int d, output logic bz, output logic dn, output logic ps,
                        output int ec, output logic [35:0] nv);
    if (d == 0) begin
      bz = b0.busy; dn = b0.done; ps = b0.pass; ec = int'(b0.err_count); nv = n0;
    end else begin
      bz = b3.busy; dn = b3.done; ps = b3.pass; ec = int'(b3.err_count); nv = n3;
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) b0.start = v; else b3.start = v;
  endtask

  task automatic load_sb(input int d);
    logic [35:0] v = SEED;
    exp_q.delete();
    for (int t = 0; t < ((d == 0) ? 16 : 32); t++) begin
      exp_q.push_back(v);
      v = step(v);
    end
  endtask

  typedef struct {
    int   dsel;
    int   mode;
    bit   mid_start;
    int   exp_err;
    bit   exp_pass;
    int   exp_busy;
  } rec_t;

  task automatic run(input rec_t r);
    logic bz, dn, ps;
    int ec, busy_n;
    logic [35:0] nv, e;
    bit done_seen;
    mode = r.mode;
    load_sb(r.dsel);
    @(negedge clk); set_start(r.dsel, 1'b1);
    @(negedge clk); set_start(r.dsel, 1'b0);
    busy_n = 0; done_seen = 0;
    for (int c = 0; c < 300; c++) begin
      sample(r.dsel, bz, dn, ps, ec, nv);
      if (dn) begin done_seen = 1; break; end
      if (bz) begin
        busy_n++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("vector", nv, e);
        end else chk("drain_zero", nv, 0);
      end
      set_start(r.dsel, r.mid_start && busy_n == 3);
      @(negedge clk);
    end
    set_start(r.dsel, 1'b0);
    chk("done_reached", done_seen, 1);
    chk("busy_cycles", busy_n, r.exp_busy);
    chk("err_count", ec, r.exp_err);
    chk("pass", ps, r.exp_pass);
    chk("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    sample(r.dsel, bz, dn, ps, ec, nv);
    chk("done_hold", dn, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {b3.busy, b0.busy}, 0);
    chk({tag, "_done_pass"}, {b3.done, b3.pass, b0.done, b0.pass}, 0);
    chk({tag, "_err"}, {b3.err_count, b0.err_count}, 0);
    chk({tag, "_nvec"}, {n3, n0}, 0);
    chk({tag, "_ferr0"}, {b0.first_err_vec, b0.first_err_idx}, 0);
  endtask

  rec_t tbl[7];

  initial begin
    logic [35:0] v;
    int s16, s32, k;
    logic bz, dn, ps;
    int ec;
    logic [35:0] nv, e;

    v = SEED; s16 = 0; s32 = 0;
    for (int t = 0; t < 32; t++) begin
      if (t == 5) flipvec = v;
      if (!v[35]) begin
        s32++;
        if (t < 16) s16++;
      end
      v = step(v);
    end
    tbl[0] = '{0, 0, 0, 0, 1, 16};
    tbl[1] = '{0, 1, 0, s16, (s16 == 0), 16};
    tbl[2] = '{0, 2, 0, 1, 0, 16};
    tbl[3] = '{3, 0, 1, 0, 1, 35};
    tbl[4] = '{3, 3, 0, 15, 0, 35};
    tbl[5] = '{3, 1, 0, (s32 > 15) ? 15 : s32, (s32 == 0), 35};
    tbl[6] = '{0, 0, 1, 0, 1, 16};

    b0.start = 1'b0;
    b3.start = 1'b0;
    #1 chk_zero("reset");
    #20 @(negedge clk) resetn = 1'b1;
    @(negedge clk) chk_zero("idle");

    for (int i = 0; i < 7; i++) begin
      run(tbl[i]);
      if (tbl[i].mode == 2) begin
`ifdef TERM_LOOP_ERRLOG_EN
        chk("first_err_vec", b0.first_err_vec, 36'h2);
        chk("first_err_idx", b0.first_err_idx, 5);
`else
        chk("first_err_tied", {b0.first_err_vec, b0.first_err_idx}, 0);
`endif
      end
    end

    // Reset in RUN cycle 7, then an identical clean rerun
    mode = 0;
    load_sb(0);
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    k = 0;
    for (int c = 0; c < 50 && k < 7; c++) begin
      sample(0, bz, dn, ps, ec, nv);
      if (bz) begin
        e = exp_q.pop_front();
        chk("pre_reset_vector", nv, e);
        k++;
      end
      if (k < 7) @(negedge clk);
    end
    chk("reached_cycle7", k, 7);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_zero("midrun_reset");
    repeat (2) @(negedge clk);
    chk_zero("reset_hold");
    resetn = 1'b1;
    run(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
